// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table (segments a..g on bits 0..6, active-high).
// Used by every counter/decoder tile so that all displays render identical glyphs.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_digit_scanner_if.sv
// Display-side bundle of the digit scanner: digit/dp/brightness controls in,
// multiplexed segment bus and digit enables out.
interface seg7_digit_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_lz;
    logic [2:0]              bright;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_start;

    modport master (
        output digits_in, dp_in, load, blank_lz, bright,
        input  seg_out, dp_out, dig_en, frame_start
    );

    modport slave (
        input  digits_in, dp_in, load, blank_lz, bright,
        output seg_out, dp_out, dig_en, frame_start
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Purely combinational nibble to 7-segment decoder built on the shared glyph table.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/seg7_digit_scanner.sv
// Time-multiplexes NUM_DIGITS nibbles onto one 7-segment bus with frame-synchronous
// capture, leading-zero blanking and 8-level PWM brightness.
module seg7_digit_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SUB_TICKS  = 125
) (
    input logic                 clk,
    input logic                 rst,
    seg7_digit_scanner_if.slave bus
);
    localparam int SUB_W  = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SUB_W-1:0]      SUB_LAST  = SUB_W'(SUB_TICKS - 1);
    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_ONE    = NUM_DIGITS'(1);

    logic [SUB_W-1:0]        sub;
    logic [2:0]              phase;
    logic [SLOT_W-1:0]       slot;
    logic                    sub_wrap, phase_wrap, boundary;
    logic [4*NUM_DIGITS-1:0] pend_digits, disp_digits;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
    logic                    pend_valid;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_above;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_seg;
    logic                    lit;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   dig_en_q;
    logic                    frame_start_q;

    assign sub_wrap   = (sub == SUB_LAST);
    assign phase_wrap = sub_wrap && (phase == 3'd7);
    assign boundary   = phase_wrap && (slot == SLOT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sub   <= '0;
            phase <= '0;
            slot  <= '0;
        end else begin
            sub <= sub_wrap ? '0 : sub + 1'b1;
            if (sub_wrap)
                phase <= phase + 1'b1;
            if (phase_wrap)
                slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        end
    end

    // Display only updates on the frame boundary; a load landing on that very cycle
    // goes straight to the display so it is not delayed by a whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            disp_digits <= '0;
            disp_dp     <= '0;
        end else if (boundary && bus.load) begin
            disp_digits <= bus.digits_in;
            disp_dp     <= bus.dp_in;
            pend_valid  <= 1'b0;
        end else if (boundary && pend_valid) begin
            disp_digits <= pend_digits;
            disp_dp     <= pend_dp;
            pend_valid  <= 1'b0;
        end else if (bus.load) begin
            pend_digits <= bus.digits_in;
            pend_dp     <= bus.dp_in;
            pend_valid  <= 1'b1;
        end
    end

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (disp_digits[4*i +: 4] == 4'h0);
            blank[i]   = bus.blank_lz && zero_above;
        end
    end

    assign cur_nibble = disp_digits[4*int'(slot) +: 4];
    assign lit        = (phase <= bus.bright);

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Segments and dp are gated by the enable so a dark digit never ghosts.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b0;
            dig_en_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            dig_en_q      <= lit ? (EN_ONE << slot) : '0;
            seg_q         <= (lit && !blank[slot]) ? cur_seg : SEG_BLANK;
            dp_q          <= lit && disp_dp[slot];
            frame_start_q <= (slot == '0) && (phase == 3'd0) && (sub == '0);
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.dp_out      = dp_q;
    assign bus.dig_en      = dig_en_q;
    assign bus.frame_start = frame_start_q;

endmodule
